// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - op and state encodings shared by decode and the mul/div sequencer
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } md_state_t;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_divu_step.sv
// rtl/muldiv_sequencer_divu_step.sv - one restoring-division step
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quotient_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The kept difference is always below the divisor, so a WIDTH-bit subtract is exact.
    assign shifted      = {rem_in, dividend_bit};
    assign quotient_bit = (shifted >= {1'b0, divisor});
    assign diff         = shifted[WIDTH-1:0] - divisor;
    assign rem_out      = quotient_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle unsigned MUL/DIVU/REMU unit with pipeline stall
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state, state_next;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   b_q;
    logic [4:0]         rd_q;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem, rem_next, quo, quo_next;
    logic               qbit, accept, div0_fast, last;

    assign accept    = (state == S_IDLE) && start && !flush;
    assign div0_fast = is_div_op(op) && (b == '0);
    assign last      = (count == CW'(WIDTH - 1));
    assign busy      = (state == S_MUL) || (state == S_DIV);
    assign done      = (state == S_DONE);
    assign stall     = (accept && !div0_fast) || busy;

    assign acc_next  = mplier[0] ? acc + mcand : acc;
    assign quo_next  = {quo[WIDTH-2:0], qbit};

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem),
        .dividend_bit (quo[WIDTH-1]),
        .divisor      (b_q),
        .rem_out      (rem_next),
        .quotient_bit (qbit)
    );

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_next = div0_fast ? S_DONE : (is_div_op(op) ? S_DIV : S_MUL);
                S_MUL:  if (last) state_next = S_DONE;
                S_DIV:  if (last) state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            op_q        <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            result      <= '0;
            rd_out      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (!flush) begin
                case (state)
                    S_IDLE: if (start) begin
                        op_q        <= op;
                        b_q         <= b;
                        rd_q        <= rd_in;
                        count       <= '0;
                        acc         <= '0;
                        mcand       <= {{WIDTH{1'b0}}, a};
                        mplier      <= b;
                        rem         <= '0;
                        quo         <= a;
                        div_by_zero <= div0_fast;
                        // Divide by zero skips iteration and writes its fixed result now.
                        if (div0_fast) begin
                            result <= (op == OP_DIVU) ? '1 : a;
                            rd_out <= rd_in;
                        end
                    end
                    S_MUL: begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + CW'(1);
                        if (last) begin
                            result <= acc_next[WIDTH-1:0];
                            rd_out <= rd_q;
                        end
                    end
                    S_DIV: begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + CW'(1);
                        if (last) begin
                            result <= (op_q == OP_REMU) ? rem_next : quo_next;
                            rd_out <= rd_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd_in;
    logic        stall, busy, done, div_by_zero;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .rd_in       (rd_in),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .rd_out      (rd_out),
        .div_by_zero (div_by_zero)
    );

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        case (o)
            2'd1:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'd2:    return (y == 0) ? x : x % y;
            default: begin
                p = {32'd0, x} * {32'd0, y};
                return p[31:0];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] r);
        int cyc;
        int st;
        logic zero;
        logic [31:0] exp;
        zero = (o == 2'd1 || o == 2'd2) && (y == 0);
        exp  = model(o, x, y);
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        #1;
        st  = stall ? 1 : 0;
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (done || cyc >= 100) break;
            if (stall) st++;
            if (cyc == 5) begin
                a = $urandom; b = $urandom_range(0, 3); op = 2'($urandom); rd_in = 5'($urandom);
            end
        end
        check({tag, " latency"}, 32'(cyc), zero ? 32'd1 : 32'd33);
        check({tag, " stall_cycles"}, 32'(st), zero ? 32'd0 : 32'd33);
        check({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, r});
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, zero});
        last_result = exp;
        last_rd     = r;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, " no_restart"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0] ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);

        run_op("mul7x6", 2'd0, 32'd7, 32'd6, 5'd3);
        run_op("mul_wrap", 2'd0, 32'hFFFF_FFFF, 32'd2, 5'd9);
        run_op("divu100_7", 2'd1, 32'd100, 32'd7, 5'd12);
        run_op("remu100_7", 2'd2, 32'd100, 32'd7, 5'd13);
        run_op("divu_by0", 2'd1, 32'd5, 32'd0, 5'd20);
        run_op("remu_by0", 2'd2, 32'd5, 32'd0, 5'd21);
        run_op("rsvd_mul", 2'd3, 32'd12345, 32'd678, 5'd31);

        // flush mid-MUL: no done, previous result retained
        op = 2'd0; a = 32'd1234; b = 32'd5678; rd_in = 5'd7; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("flush_pre done", {31'd0, done}, 32'd0);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result", result, last_result);
        check("flush rd_out", {27'd0, rd_out}, {27'd0, last_rd});
        @(posedge clk); #1;
        run_op("after_flush", 2'd0, 32'd1234, 32'd5678, 5'd7);

        // flush and start together in IDLE: start ignored
        op = 2'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", {31'd0, busy}, 32'd0);
        check("flush_start done", {31'd0, done}, 32'd0);

        for (int n = 0; n < 16; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", n), ro, ra, rb, 5'($urandom));
        end

        // reset at iteration 20 of a DIVU
        op = 2'd1; a = 32'd1000; b = 32'd3; rd_in = 5'd17; start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("midreset result", result, 32'd0);
        check("midreset rd_out", {27'd0, rd_out}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        check("midreset no_done", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
